// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side signals of the two-port data-memory arbiter.
// The arbiter takes the slave view; requesters plus memory take the master view.
interface dmem_arbiter_if #(
  parameter int MEM_AW = 8
);
  logic              req0_vld, req0_rdy, req0_wr;
  logic [31:0]       req0_addr, req0_wdata;
  logic [3:0]        req0_be;
  logic              req1_vld, req1_rdy, req1_wr, req1_lock;
  logic [31:0]       req1_addr, req1_wdata;
  logic [3:0]        req1_be;
  logic              rsp0_vld, rsp0_err;
  logic [31:0]       rsp0_rdata;
  logic              rsp1_vld, rsp1_err;
  logic [31:0]       rsp1_rdata;
  logic              mem_en, mem_wr;
  logic [MEM_AW-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata, mem_rdata;

  modport slave (
    input  req0_vld, req0_wr, req0_addr, req0_be, req0_wdata,
    input  req1_vld, req1_wr, req1_addr, req1_be, req1_wdata, req1_lock,
    input  mem_rdata,
    output req0_rdy, req1_rdy,
    output rsp0_vld, rsp0_err, rsp0_rdata, rsp1_vld, rsp1_err, rsp1_rdata,
    output mem_en, mem_wr, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req0_vld, req0_wr, req0_addr, req0_be, req0_wdata,
    output req1_vld, req1_wr, req1_addr, req1_be, req1_wdata, req1_lock,
    output mem_rdata,
    input  req0_rdy, req1_rdy,
    input  rsp0_vld, rsp0_err, rsp0_rdata, rsp1_vld, rsp1_err, rsp1_rdata,
    input  mem_en, mem_wr, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the byte-column data memory between the LSU (port 0)
// and the debug/loader port (port 1), with a bounded port-1 lock mode for bursts.
module dmem_arbiter #(
  parameter int MEM_AW   = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.slave bus
);
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LMAX = LW'(MAX_LOCK);

  typedef enum logic {RR, LOCK1} state_t;

  state_t        state, state_nxt;
  logic          prio, prio_nxt, eff_prio;
  logic [LW-1:0] lcnt, lcnt_nxt;
  logic          gnt, gport, take;

  logic          wr_s, in_range;
  logic [31:2]   addr_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;

  logic          rsp_vld, rsp_port, rsp_rd, rsp_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RR;
      prio  <= 1'b0;
      lcnt  <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      lcnt  <= lcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    lcnt_nxt  = lcnt;
    eff_prio  = prio;
    gnt       = 1'b0;
    gport     = 1'b0;
    if (state == LOCK1 && bus.req1_vld && bus.req1_lock) begin
      gnt = 1'b1;
      // Port 0 has waited through MAX_LOCK port-1 grants: give it one slot.
      if (lcnt == LMAX && bus.req0_vld) begin
        gport    = 1'b0;
        lcnt_nxt = '0;
        prio_nxt = 1'b1;
      end else begin
        gport    = 1'b1;
        prio_nxt = 1'b0;
        if (bus.req0_vld && lcnt != LMAX) lcnt_nxt = lcnt + 1'b1;
      end
    end else begin
      // Leaving the lock re-bases round robin on port 0 for this very cycle.
      if (state == LOCK1) begin
        state_nxt = RR;
        eff_prio  = 1'b0;
        prio_nxt  = 1'b0;
        lcnt_nxt  = '0;
      end
      if (bus.req0_vld || bus.req1_vld) begin
        gnt      = 1'b1;
        gport    = (bus.req0_vld && bus.req1_vld) ? eff_prio : bus.req1_vld;
        prio_nxt = ~gport;
        if (gport && bus.req1_lock) begin
          state_nxt = LOCK1;
          lcnt_nxt  = LW'(1);
        end
      end
    end
  end

  assign take         = gnt && !reset;
  assign bus.req0_rdy = take && !gport;
  assign bus.req1_rdy = take && gport;

  assign wr_s     = gport ? bus.req1_wr           : bus.req0_wr;
  assign addr_s   = gport ? bus.req1_addr[31:2]   : bus.req0_addr[31:2];
  assign be_s     = gport ? bus.req1_be           : bus.req0_be;
  assign wdata_s  = gport ? bus.req1_wdata        : bus.req0_wdata;
  assign in_range = (addr_s[31:MEM_AW+2] == '0);

  // A write with no byte enables still claims the slot but writes nothing.
  assign bus.mem_en    = take && in_range;
  assign bus.mem_wr    = bus.mem_en && wr_s && (be_s != 4'b0);
  assign bus.mem_be    = bus.mem_wr ? be_s : 4'b0;
  assign bus.mem_addr  = bus.mem_en ? addr_s[MEM_AW+1:2] : '0;
  assign bus.mem_wdata = bus.mem_wr ? wdata_s : 32'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld  <= 1'b0;
      rsp_port <= 1'b0;
      rsp_rd   <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      rsp_vld  <= take;
      rsp_port <= gport;
      rsp_rd   <= take && in_range && !wr_s;
      rsp_err  <= take && !in_range;
    end
  end

  assign bus.rsp0_vld   = rsp_vld && !rsp_port && !reset;
  assign bus.rsp1_vld   = rsp_vld && rsp_port && !reset;
  assign bus.rsp0_err   = bus.rsp0_vld && rsp_err;
  assign bus.rsp1_err   = bus.rsp1_vld && rsp_err;
  assign bus.rsp0_rdata = (bus.rsp0_vld && rsp_rd) ? bus.mem_rdata : 32'b0;
  assign bus.rsp1_rdata = (bus.rsp1_vld && rsp_rd) ? bus.mem_rdata : 32'b0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural memory, shadow-memory scoreboard
// of expected responses, and a grant log checked against expected sequences.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.MEM_AW(8)) bus ();
  dmem_arbiter #(.MEM_AW(8), .MAX_LOCK(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  int   glog[$];
  int   exp_g[$];
  logic acc0, acc1;
  logic [31:0] last_rdata0, last_rdata1;
  logic        last_err0, last_err1;

  logic [31:0] mem    [256] = '{0: 32'h11223344, 1: 32'h55667788, default: 32'h0};
  logic [31:0] shadow [256] = '{0: 32'h11223344, 1: 32'h55667788, default: 32'h0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: four byte columns sharing one word address, read data one cycle later.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr) begin
        for (int k = 0; k < 4; k++)
          if (bus.mem_be[k]) mem[bus.mem_addr][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  function automatic exp_t model(input logic p, input logic w, input logic [31:0] a,
                                 input logic [3:0] b, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.err = (a[31:10] != 0);
    e.rdata = 32'h0;
    if (!e.err) begin
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) shadow[a[9:2]][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.rdata = shadow[a[9:2]];
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (reset) begin
      chk("reset_outs", {bus.req0_rdy, bus.req1_rdy, bus.rsp0_vld, bus.rsp1_vld,
                         bus.rsp0_err, bus.rsp1_err, bus.mem_en, bus.mem_wr, bus.mem_be,
                         |bus.rsp0_rdata, |bus.rsp1_rdata, |bus.mem_addr, |bus.mem_wdata}, 64'h0);
      sb.delete();
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_vld", {bus.rsp1_vld, bus.rsp0_vld}, e.port ? 2'b10 : 2'b01);
        chk("rsp_err", e.port ? bus.rsp1_err : bus.rsp0_err, e.err);
        chk("rsp_rdata", e.port ? bus.rsp1_rdata : bus.rsp0_rdata, e.rdata);
      end else begin
        chk("rsp_idle", {bus.rsp1_vld, bus.rsp0_vld}, 2'b00);
      end
      if (bus.rsp0_vld) begin last_rdata0 = bus.rsp0_rdata; last_err0 = bus.rsp0_err; end
      if (bus.rsp1_vld) begin last_rdata1 = bus.rsp1_rdata; last_err1 = bus.rsp1_err; end
      chk("rdy_rules", {bus.req0_rdy & ~bus.req0_vld, bus.req1_rdy & ~bus.req1_vld,
                        bus.req0_rdy & bus.req1_rdy}, 3'b000);
      if (bus.req0_vld && bus.req0_rdy) begin
        acc0 = 1'b1;
        glog.push_back(0);
        sb.push_back(model(1'b0, bus.req0_wr, bus.req0_addr, bus.req0_be, bus.req0_wdata));
      end
      if (bus.req1_vld && bus.req1_rdy) begin
        acc1 = 1'b1;
        glog.push_back(1);
        sb.push_back(model(1'b1, bus.req1_wr, bus.req1_addr, bus.req1_be, bus.req1_wdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
    bus.req0_vld = v; bus.req0_wr = w; bus.req0_addr = a; bus.req0_be = b; bus.req0_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d, input logic lk);
    bus.req1_vld = v; bus.req1_wr = w; bus.req1_addr = a; bus.req1_be = b; bus.req1_wdata = d;
    bus.req1_lock = lk;
  endtask

  task automatic wait_acc(input int p, input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = (p == 0) ? acc0 : acc1;
    end
    chk(tag, got, 1'b1);
  endtask

  initial begin
    int i1;
    reset = 1'b1;
    drv0(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    drv1(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0);
    repeat (3) tick();

    // Round robin: continuous reads from both ports straight out of reset.
    glog.delete();
    reset = 1'b0;
    repeat (8) tick();
    drv0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drv1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("rr_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("rr_order", glog[i], i % 2);
    tick();

    // Byte-column write then read of the same word.
    drv0(1'b1, 1'b1, 32'h8, 4'b0010, 32'hAABBCCDD);
    wait_acc(0, "bw_wr_acc");
    drv0(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    wait_acc(0, "bw_rd_acc");
    drv0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    chk("bw_rdata", last_rdata0, 32'h0000CC00);
    chk("bw_err", last_err0, 1'b0);

    // Out-of-range read: accepted, no memory access, error response.
    drv1(1'b1, 1'b0, 32'h400, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rng_rdy", bus.req1_rdy, 1'b1);
    chk("rng_mem_en", bus.mem_en, 1'b0);
    wait_acc(1, "rng_acc");
    drv1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    tick();
    chk("rng_err", last_err1, 1'b1);
    chk("rng_rdata", last_rdata1, 32'h0);

    // Lock fairness: 40 locked port-1 writes against a constantly waiting port 0,
    // then 6 unlocked port-1 reads to see alternation come back.
    glog.delete();
    i1 = 0;
    drv0(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    drv1(1'b1, 1'b1, 32'h10, 4'hF, 32'hA0000000, 1'b1);
    for (int c = 0; c < 200 && i1 < 46; c++) begin
      tick();
      if (acc1) begin
        i1++;
        if (i1 < 40)      drv1(1'b1, 1'b1, 32'h10 + 4 * i1, 4'hF, 32'hA0000000 + i1, 1'b1);
        else if (i1 < 46) drv1(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0);
        else begin
          drv1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
          drv0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
      end
    end
    chk("lock_done", i1, 46);
    exp_g.delete();
    exp_g.push_back(0);
    for (int k = 1; k <= 40; k++) begin
      exp_g.push_back(1);
      if (k == 16 || k == 32) exp_g.push_back(0);
    end
    for (int k = 0; k < 6; k++) begin exp_g.push_back(0); exp_g.push_back(1); end
    chk("lock_count", glog.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < glog.size(); i++) chk("lock_order", glog[i], exp_g[i]);
    tick();
    tick();

    // Reset mid-operation: port-0 read accepted at T, reset raised at T+1.
    drv1(1'b1, 1'b1, 32'h200, 4'hF, 32'hDEAD0001, 1'b1);
    wait_acc(1, "rm_lock_acc");
    drv1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    drv0(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    wait_acc(0, "rm_rd_acc");
    reset = 1'b1;
    drv0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rm_rsp0", bus.rsp0_vld, 1'b0);
    tick();
    reset = 1'b0;
    glog.delete();
    drv0(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    drv1(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b1);
    tick();
    tick();
    drv0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drv1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("rm_count", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("rm_first", glog[0], 0);
      chk("rm_second", glog[1], 1);
    end
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
